// File: rtl/tow_led_monitor_if.sv
// tow_led_monitor_if: game LED bus plus the decoded report of the tug-of-war monitor.
// master drives the LED bus, slave (the monitor) drives the report.
interface tow_led_monitor_if #(parameter int CNT_W = 8);
    logic [6:0]        led_in;
    logic signed [2:0] pos;
    logic              move_valid;
    logic              move_dir;
    logic              win_valid;
    logic              winner;
    logic              game_active;
    logic              illegal;
    logic [CNT_W-1:0]  moves_left;
    logic [CNT_W-1:0]  moves_right;
    modport master (output led_in, input pos, move_valid, move_dir, win_valid, winner,
                    game_active, illegal, moves_left, moves_right);
    modport slave  (input led_in, output pos, move_valid, move_dir, win_valid, winner,
                    game_active, illegal, moves_left, moves_right);
endinterface

// File: rtl/tow_led_monitor.sv
// tow_led_monitor: glitch-filtered decoder of the tug-of-war LED sequence into moves, wins and violations.
// Define TOW_MON_SYNC_EN to put a 2-flop synchronizer in front of the filter (+2 cycles latency).
module tow_led_monitor #(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    tow_led_monitor_if.slave  bus
);
    localparam int RW = $clog2(STABLE_CYCLES + 2);
    localparam logic [6:0] P_RST = 7'b1111111, P_WL = 7'b1110000, P_WR = 7'b0000111, P_N0 = 7'b0001000;
    typedef enum logic [2:0] {IDLE, RESETSEEN, DARKINIT, PLAY, DARK, WIN, ERR} state_t;
    state_t           r_state, w_state;
    logic [6:0]       w_samp, r_prev, r_pat;
    logic [RW-1:0]    r_run, w_run;
    logic             r_acc;
    logic [2:0]       r_pos, w_pos, w_p;
    logic [3:0]       w_d;
    logic             r_mv, w_mv, r_wv, w_wv, r_dir, w_dir, r_winner, w_winner, r_ill, w_ill, r_active;
    logic [CNT_W-1:0] r_ml, w_ml, r_mr, w_mr, w_ml_inc, w_mr_inc;
    logic             w_rst, w_dark, w_onehot, w_step;
`ifdef TOW_MON_SYNC_EN
    logic [6:0] r_sync1, r_sync2;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.led_in;
            r_sync2 <= r_sync1;
        end
    assign w_samp = r_sync2;
`else
    assign w_samp = bus.led_in;
`endif
    // run counter parks at STABLE_CYCLES+1 so each run is accepted exactly once
    assign w_run = (r_run == '0 || w_samp != r_prev) ? RW'(1)
                 : (r_run == RW'(STABLE_CYCLES + 1)) ? r_run : r_run + 1'b1;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_prev <= '0;
            r_run  <= '0;
            r_acc  <= 1'b0;
            r_pat  <= '0;
        end else begin
            r_prev <= w_samp;
            r_run  <= w_run;
            r_acc  <= (w_run == RW'(STABLE_CYCLES));
            if (w_run == RW'(STABLE_CYCLES)) r_pat <= w_samp;
        end
    assign w_rst    = (r_pat == P_RST);
    assign w_dark   = (r_pat == 7'b0000000);
    assign w_onehot = $onehot(r_pat);
    assign w_p      = r_pat[6] ? 3'b101 : r_pat[5] ? 3'b110 : r_pat[4] ? 3'b111 : r_pat[3] ? 3'b000 :
                      r_pat[2] ? 3'b001 : r_pat[1] ? 3'b010 : 3'b011;
    assign w_d      = {w_p[2], w_p} - {r_pos[2], r_pos};
    assign w_step   = w_onehot && (w_d == 4'b0001 || w_d == 4'b1111);
    assign w_ml_inc = (&r_ml) ? r_ml : r_ml + 1'b1;
    assign w_mr_inc = (&r_mr) ? r_mr : r_mr + 1'b1;
    always_comb begin
        w_state  = r_state;
        w_pos    = r_pos;
        w_mv     = 1'b0;
        w_wv     = 1'b0;
        w_dir    = r_dir;
        w_winner = r_winner;
        w_ill    = r_ill;
        w_ml     = r_ml;
        w_mr     = r_mr;
        if (r_acc) begin
            if (w_rst) begin
                w_state  = RESETSEEN;
                w_pos    = '0;
                w_dir    = 1'b0;
                w_winner = 1'b0;
                w_ill    = 1'b0;
                w_ml     = '0;
                w_mr     = '0;
            end else begin
                // a re-accepted copy of the current pattern (after a rejected glitch) is benign
                case (r_state)
                    RESETSEEN: w_state = w_dark ? DARKINIT : ERR;
                    DARKINIT:  w_state = w_dark ? DARKINIT : (r_pat == P_N0) ? PLAY : ERR;
                    PLAY:      w_state = w_dark ? DARK : (w_onehot && w_d == 4'b0000) ? PLAY : ERR;
                    DARK: begin
                        if (w_onehot && w_d == 4'b0000) w_state = PLAY;
                        else if (w_step) begin
                            w_state = PLAY;
                            w_mv    = 1'b1;
                            w_pos   = w_p;
                            w_dir   = (w_d == 4'b0001);
                            w_ml    = (w_d == 4'b0001) ? r_ml : w_ml_inc;
                            w_mr    = (w_d == 4'b0001) ? w_mr_inc : r_mr;
                        end else if ((r_pat == P_WL && r_pos == 3'b101) || (r_pat == P_WR && r_pos == 3'b011)) begin
                            w_state  = WIN;
                            w_wv     = 1'b1;
                            w_winner = (r_pat == P_WR);
                            w_dir    = (r_pat == P_WR);
                            w_ml     = (r_pat == P_WR) ? r_ml : w_ml_inc;
                            w_mr     = (r_pat == P_WR) ? w_mr_inc : r_mr;
                        end else if (!w_dark) w_state = ERR;
                    end
                    default: ;
                endcase
                if (w_state == ERR) w_ill = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_mv     <= 1'b0;
            r_wv     <= 1'b0;
            r_dir    <= 1'b0;
            r_winner <= 1'b0;
            r_ill    <= 1'b0;
            r_active <= 1'b0;
            r_ml     <= '0;
            r_mr     <= '0;
        end else begin
            r_state  <= w_state;
            r_pos    <= w_pos;
            r_mv     <= w_mv;
            r_wv     <= w_wv;
            r_dir    <= w_dir;
            r_winner <= w_winner;
            r_ill    <= w_ill;
            r_active <= (w_state == PLAY || w_state == DARK);
            r_ml     <= w_ml;
            r_mr     <= w_mr;
        end
    assign bus.pos         = r_pos;
    assign bus.move_valid  = r_mv;
    assign bus.move_dir    = r_dir;
    assign bus.win_valid   = r_wv;
    assign bus.winner      = r_winner;
    assign bus.game_active = r_active;
    assign bus.illegal     = r_ill;
    assign bus.moves_left  = r_ml;
    assign bus.moves_right = r_mr;
endmodule

// File: tb/tb_tow_led_monitor.sv
// tb_tow_led_monitor: directed game sequences; expected strobes queued by stimulus, checked by a monitor.
// A second instance with CNT_W=2 sees the same LED bus to exercise counter saturation.
module tb_tow_led_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] led;
    always #5 clk = ~clk;
    localparam logic [6:0] RS = 7'b1111111, DK = 7'b0000000, WL = 7'b1110000, WR = 7'b0000111;
    localparam logic [6:0] L3 = 7'b1000000, L2 = 7'b0100000, L1 = 7'b0010000, N0 = 7'b0001000;
    localparam logic [6:0] R1 = 7'b0000100, R2 = 7'b0000010, R3 = 7'b0000001;
    tow_led_monitor_if #(.CNT_W(8)) m();
    tow_led_monitor_if #(.CNT_W(2)) s();
    assign m.led_in = led;
    assign s.led_in = led;
    tow_led_monitor #(.STABLE_CYCLES(2), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(m.slave));
    tow_led_monitor #(.STABLE_CYCLES(2), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(s.slave));
    typedef struct {
        bit w;
        int pos;
        bit dir;
        bit winner;
        int ml;
        int mr;
    } ev_t;
    ev_t q[$];
    int ntests = 0;
    int nfail  = 0;
    task automatic chk(input string n, input int a, input int e);
        ntests++;
        if (a != e) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", n, a, e);
        end
    endtask
    task automatic drive(input logic [6:0] p, input int n);
        led = p;
        repeat (n) @(negedge clk);
    endtask
    task automatic ev(input logic [6:0] p, input bit w, input int pos, input bit dir, input bit winner,
                      input int ml, input int mr);
        drive(DK, 4);
        q.push_back('{w: w, pos: pos, dir: dir, winner: winner, ml: ml, mr: mr});
        drive(p, 4);
    endtask
    task automatic start();
        drive(RS, 4);
        drive(DK, 4);
        drive(N0, 4);
    endtask
    always @(negedge clk)
        if (rst && (m.move_valid || m.win_valid)) begin
            chk("strobe_excl", int'(m.move_valid && m.win_valid), 0);
            if (q.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                automatic ev_t e = q.pop_front();
                chk("ev_kind_win", int'(m.win_valid), int'(e.w));
                chk("ev_pos", int'(m.pos), e.pos);
                chk("ev_dir", int'(m.move_dir), int'(e.dir));
                chk("ev_moves_left", int'(m.moves_left), e.ml);
                chk("ev_moves_right", int'(m.moves_right), e.mr);
                if (e.w) chk("ev_winner", int'(m.winner), int'(e.winner));
            end
        end
    initial begin
        led = DK;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_pos", int'(m.pos), 0);
        chk("rst_move_valid", int'(m.move_valid), 0);
        chk("rst_win_valid", int'(m.win_valid), 0);
        chk("rst_dir", int'(m.move_dir), 0);
        chk("rst_winner", int'(m.winner), 0);
        chk("rst_active", int'(m.game_active), 0);
        chk("rst_illegal", int'(m.illegal), 0);
        chk("rst_ml", int'(m.moves_left), 0);
        chk("rst_mr", int'(m.moves_right), 0);
        drive(N0, 4);
        chk("idle_ignore_active", int'(m.game_active), 0);
        chk("idle_ignore_illegal", int'(m.illegal), 0);
        start();
        chk("start_active", int'(m.game_active), 1);
        chk("start_pos", int'(m.pos), 0);
        chk("start_illegal", int'(m.illegal), 0);
        ev(L1, 0, -1, 0, 0, 1, 0);
        ev(L2, 0, -2, 0, 0, 2, 0);
        ev(L3, 0, -3, 0, 0, 3, 0);
        ev(WL, 1, -3, 0, 0, 4, 0);
        chk("lwin_ml", int'(m.moves_left), 4);
        chk("lwin_winner", int'(m.winner), 0);
        chk("lwin_active", int'(m.game_active), 0);
        chk("lwin_sat_ml", int'(s.moves_left), 3);
        start();
        ev(L1, 0, -1, 0, 0, 1, 0);
        ev(L2, 0, -2, 0, 0, 2, 0);
        ev(L1, 0, -1, 1, 0, 2, 1);
        ev(N0, 0,  0, 1, 0, 2, 2);
        ev(R1, 0,  1, 1, 0, 2, 3);
        ev(R2, 0,  2, 1, 0, 2, 4);
        ev(R3, 0,  3, 1, 0, 2, 5);
        ev(WR, 1,  3, 1, 1, 2, 6);
        chk("rwin_ml", int'(m.moves_left), 2);
        chk("rwin_mr", int'(m.moves_right), 6);
        chk("rwin_winner", int'(m.winner), 1);
        chk("rwin_pos", int'(m.pos), 3);
        chk("rwin_sat_mr", int'(s.moves_right), 3);
        start();
        ev(R1, 0, 1, 1, 0, 0, 1);
        ev(N0, 0, 0, 0, 0, 1, 1);
        drive(DK, 4);
        drive(L1, 1);
        drive(DK, 4);
        chk("glitch_pos", int'(m.pos), 0);
        chk("glitch_illegal", int'(m.illegal), 0);
        chk("glitch_active", int'(m.game_active), 1);
        drive(L2, 4);
        chk("viol_illegal", int'(m.illegal), 1);
        chk("viol_active", int'(m.game_active), 0);
        drive(N0, 4);
        drive(DK, 4);
        drive(N0, 4);
        chk("err_hold_illegal", int'(m.illegal), 1);
        chk("err_hold_pos", int'(m.pos), 0);
        drive(RS, 4);
        chk("clr_illegal", int'(m.illegal), 0);
        chk("clr_ml", int'(m.moves_left), 0);
        chk("clr_mr", int'(m.moves_right), 0);
        drive(DK, 4);
        drive(N0, 4);
        for (int k = 1; k <= 6; k++) begin
            ev(L1, 0, -1, 0, 0, k, k - 1);
            ev(N0, 0,  0, 1, 0, k, k);
        end
        chk("sat_ml", int'(s.moves_left), 3);
        chk("sat_mr", int'(s.moves_right), 3);
        drive(DK, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_pos", int'(m.pos), 0);
        chk("arst_dir", int'(m.move_dir), 0);
        chk("arst_ml", int'(m.moves_left), 0);
        chk("arst_mr", int'(m.moves_right), 0);
        chk("arst_active", int'(m.game_active), 0);
        chk("arst_illegal", int'(m.illegal), 0);
        chk("arst_winner", int'(m.winner), 0);
        chk("arst_strobes", int'(m.move_valid || m.win_valid), 0);
        chk("arst_sat_ml", int'(s.moves_left), 0);
        chk("arst_sat_active", int'(s.game_active), 0);
        #10 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
